// File: rtl/seq_det_param.sv
// Parametrised serial pattern detector.
// A runtime-loadable PAT_W-bit pattern is matched against a qualified serial
// stream, with overlapping or non-overlapping detection. The match pulse is
// registered and lasts one cycle. A saturating counter tallies the matches.
// The release of reset is expected to be synchronous to clock; the upstream
// reset controller is responsible for that.

module seq_det_param #(
   parameter int unsigned            PAT_W   = 4,
   parameter logic [PAT_W-1:0]       PATTERN = 4'b1011,
   parameter logic                   OVERLAP = 1'b1,
   parameter int unsigned            CNT_W   = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             din,
   input  logic             din_valid,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic             cfg_overlap,
   input  logic             cnt_clr,
   output logic             dout,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
);

   localparam int unsigned FILL_W = $clog2(PAT_W + 1);

   // fill must already hold PAT_W-1 bits for the incoming bit to complete a match
   localparam logic [FILL_W-1:0] FILL_HIT = FILL_W'(PAT_W - 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
   localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

   logic [PAT_W-1:0] pat_q,   pat_d;
   logic             ovl_q,   ovl_d;
   logic [PAT_W-1:0] shreg_q, shreg_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic             dout_q,  dout_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             sat_q,   sat_d;

   logic [PAT_W-1:0] shreg_next_s;
   logic             hit_s;

   // Match is evaluated on the incoming bit so detection adds no latency.
   always_comb begin
      shreg_next_s = {shreg_q[PAT_W-2:0], din};
      hit_s        = din_valid & ~cfg_load & (shreg_next_s == pat_q) & (fill_q >= FILL_HIT);
   end

   // Configuration, history and fill tracking; cfg_load wins over din_valid.
   always_comb begin
      pat_d   = pat_q;
      ovl_d   = ovl_q;
      shreg_d = shreg_q;
      fill_d  = fill_q;
      if (cfg_load) begin
         pat_d   = cfg_pattern;
         ovl_d   = cfg_overlap;
         shreg_d = {PAT_W{1'b0}};
         fill_d  = {FILL_W{1'b0}};
      end else if (din_valid) begin
         shreg_d = shreg_next_s;
         if (hit_s && !ovl_q) begin
            // non-overlapping: the next match must be built from fresh bits
            fill_d = {FILL_W{1'b0}};
         end else if (fill_q < FILL_MAX) begin
            fill_d = fill_q + FILL_ONE;
         end else begin
            fill_d = fill_q;
         end
      end else begin
         // gap in the stream: everything holds, so gaps are transparent
         shreg_d = shreg_q;
         fill_d  = fill_q;
      end
   end

   // Match pulse and saturating counter; a clear beats a coincident hit.
   always_comb begin
      dout_d = hit_s;
      cnt_d  = cnt_q;
      if (cnt_clr) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (hit_s && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
      sat_d = (cnt_d == CNT_MAX);
   end

   // State registers; reset drops all history and the outputs immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pat_q   <= PATTERN;
         ovl_q   <= OVERLAP;
         shreg_q <= {PAT_W{1'b0}};
         fill_q  <= {FILL_W{1'b0}};
         dout_q  <= 1'b0;
         cnt_q   <= {CNT_W{1'b0}};
         sat_q   <= 1'b0;
      end else begin
         pat_q   <= pat_d;
         ovl_q   <= ovl_d;
         shreg_q <= shreg_d;
         fill_q  <= fill_d;
         dout_q  <= dout_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
      end
   end

   assign dout      = dout_q;
   assign match_cnt = cnt_q;
   assign cnt_sat   = sat_q;

endmodule
